// File: rtl/mux16_sched_pkg.sv
// Shared types and sizing for the 16-requester round-robin mux scheduler.
package mux16_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int NUM_REQ      = 16;
  localparam int SEL_W        = 4;
  localparam int MAX_HOLD_DEF = 8;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority pick: first set request bit at or after ptr, wrapping modulo 16.
module rr_priority_pick
  import mux16_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);

  logic [NUM_REQ-1:0] rot;
  logic [SEL_W-1:0]   off;

  always_comb begin
    // bit 0 of rot is req[ptr], so the lowest set bit is the winner's offset from ptr
    rot = NUM_REQ'({req, req} >> ptr);
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    found = |req;
    idx   = off + ptr;
  end

endmodule

// File: rtl/mux16_rr_scheduler.sv
// Round-robin owner of a shared 16:1 mux select with a bounded hold quantum and early release.
// state | meaning
// IDLE  | no grant; arbitrate among req from ptr on, one dead cycle after every release
// GRANT | sel/gnt drive requester sel; release on done, dropped req[sel] or quantum expiry
module mux16_rr_scheduler
  import mux16_sched_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] gnt,
  output logic               valid,
  output logic               busy
);

  localparam logic [SEL_W-1:0] HOLD_LAST = SEL_W'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_found;
  logic               release_now;

  rr_priority_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign release_now = done || !req[sel_q] || (cnt_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_found) begin
          state_d         = GRANT;
          sel_d           = pick_idx;
          gnt_d[pick_idx] = 1'b1;
          cnt_d           = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + SEL_W'(1);
        end else begin
          cnt_d = cnt_q + SEL_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel   = sel_q;
  assign gnt   = gnt_q;
  assign valid = (state_q == GRANT);
  assign busy  = (state_q == GRANT);

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural arbiter model.
module tb_mux16_rr_scheduler;

  localparam int MAX_HOLD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = 16'h0;
  logic        done = 1'b0;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        valid;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  // model: who owns the mux, next priority start, cycles the grant has been visible
  bit m_busy;
  int m_sel;
  int m_ptr;
  int m_held;

  mux16_rr_scheduler #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .done  (done),
    .sel   (sel),
    .gnt   (gnt),
    .valid (valid),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic void model_update();
    if (rst) begin
      m_busy = 0; m_sel = 0; m_ptr = 0; m_held = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < 16; k++) begin
        int cand;
        cand = (m_ptr + k) % 16;
        if (req[cand]) begin
          m_busy = 1; m_sel = cand; m_held = 1;
          break;
        end
      end
    end else if (done || !req[m_sel] || m_held >= MAX_HOLD) begin
      m_busy = 0;
      m_ptr  = (m_sel + 1) % 16;
    end else begin
      m_held++;
    end
  endfunction

  function automatic logic [15:0] exp_gnt();
    logic [15:0] one;
    one = 16'h1;
    return m_busy ? (one << m_sel) : 16'h0;
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 16'h0; done = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 16'hFFFF; done = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      if (gnt !== 16'h0) begin n_fail++; $display("FAIL reset_gnt cyc=%0d got=%h exp=0000", c, gnt); end
      n_tests++;
      if (valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_valid cyc=%0d got=%b/%b exp=0/0", c, valid, busy); end
      n_tests++;
      if (sel !== 4'd0) begin n_fail++; $display("FAIL reset_sel cyc=%0d got=%0d exp=0", c, sel); end
      n_tests++;
    end
    rst = 1'b0;
    step();
    if (gnt !== 16'h0001 || sel !== 4'd0 || valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_first_grant got gnt=%h sel=%0d valid=%b exp gnt=0001 sel=0 valid=1", gnt, sel, valid);
    end
    n_tests++;
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 16'hFFFF; done = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      bit exp_v;
      step();
      exp_v = (k % 2) == 1;
      if (valid !== exp_v) begin n_fail++; $display("FAIL rr_valid k=%0d got=%b exp=%b", k, valid, exp_v); end
      n_tests++;
      if (exp_v && sel !== 4'(((k - 1) / 2) % 16)) begin
        n_fail++; $display("FAIL rr_sel k=%0d got=%0d exp=%0d", k, sel, ((k - 1) / 2) % 16);
      end
      if (exp_v) n_tests++;
      if (gnt !== exp_gnt()) begin n_fail++; $display("FAIL rr_gnt k=%0d got=%h exp=%h", k, gnt, exp_gnt()); end
      n_tests++;
    end
    done = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    req = 16'h0100; done = 1'b0;
    for (int c = 1; c <= MAX_HOLD; c++) begin
      step();
      if (gnt !== 16'h0100 || sel !== 4'd8) begin
        n_fail++; $display("FAIL timeout_hold cyc=%0d got gnt=%h sel=%0d exp gnt=0100 sel=8", c, gnt, sel);
      end
      n_tests++;
    end
    step();
    if (valid !== 1'b0 || gnt !== 16'h0) begin n_fail++; $display("FAIL timeout_dead got valid=%b gnt=%h exp 0/0000", valid, gnt); end
    n_tests++;
    step();
    if (gnt !== 16'h0100 || valid !== 1'b1) begin n_fail++; $display("FAIL timeout_regrant got gnt=%h valid=%b exp 0100/1", gnt, valid); end
    n_tests++;
  endtask

  task automatic test_wrap();
    do_reset();
    req = 16'h4000; done = 1'b0;
    step();
    if (sel !== 4'd14 || valid !== 1'b1) begin n_fail++; $display("FAIL wrap_g14 got sel=%0d valid=%b exp 14/1", sel, valid); end
    n_tests++;
    done = 1'b1;
    step();
    req = 16'h8001; done = 1'b0;
    step();
    if (gnt !== 16'h8000 || sel !== 4'd15) begin n_fail++; $display("FAIL wrap_g15 got gnt=%h sel=%0d exp 8000/15", gnt, sel); end
    n_tests++;
    done = 1'b1;
    step();
    if (valid !== 1'b0) begin n_fail++; $display("FAIL wrap_dead got valid=%b exp 0", valid); end
    n_tests++;
    done = 1'b0;
    step();
    if (gnt !== 16'h0001 || sel !== 4'd0) begin n_fail++; $display("FAIL wrap_g0 got gnt=%h sel=%0d exp 0001/0", gnt, sel); end
    n_tests++;
  endtask

  task automatic test_early_drop();
    do_reset();
    req = 16'h0008; done = 1'b0;
    step();
    step();
    if (gnt !== 16'h0008) begin n_fail++; $display("FAIL drop_pre got gnt=%h exp 0008", gnt); end
    n_tests++;
    req = 16'h0000;
    step();
    if (valid !== 1'b0) begin n_fail++; $display("FAIL drop_release got valid=%b exp 0", valid); end
    n_tests++;
    req = 16'h0018;
    step();
    if (sel !== 4'd4 || gnt !== 16'h0010) begin n_fail++; $display("FAIL drop_ptr got sel=%0d gnt=%h exp 4/0010", sel, gnt); end
    n_tests++;

    do_reset();
    req = 16'h0003; done = 1'b0;
    for (int c = 1; c <= MAX_HOLD; c++) step();
    if (gnt !== 16'h0001) begin n_fail++; $display("FAIL simul_pre got gnt=%h exp 0001", gnt); end
    n_tests++;
    done = 1'b1;
    step();
    if (valid !== 1'b0) begin n_fail++; $display("FAIL simul_release got valid=%b exp 0", valid); end
    n_tests++;
    done = 1'b0;
    step();
    if (sel !== 4'd1 || gnt !== 16'h0002) begin n_fail++; $display("FAIL simul_ptr got sel=%0d gnt=%h exp 1/0002", sel, gnt); end
    n_tests++;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 16'h0020; done = 1'b0;
    for (int c = 0; c < 4; c++) step();
    if (sel !== 4'd5 || valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre got sel=%0d valid=%b exp 5/1", sel, valid); end
    n_tests++;
    rst = 1'b1;
    step();
    if (gnt !== 16'h0 || sel !== 4'd0 || valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_clear got gnt=%h sel=%0d valid=%b exp 0000/0/0", gnt, sel, valid);
    end
    n_tests++;
    rst = 1'b0; req = 16'h0021;
    step();
    if (gnt !== 16'h0001 || sel !== 4'd0) begin n_fail++; $display("FAIL midrst_next got gnt=%h sel=%0d exp 0001/0", gnt, sel); end
    n_tests++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      case ($urandom_range(0, 3))
        0: req = 16'h1 << $urandom_range(0, 15);
        1: req = 16'h0;
        default: req = 16'($urandom);
      endcase
      done = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 63) == 0);
      step();
      if (gnt !== exp_gnt()) begin n_fail++; $display("FAIL rand_gnt cyc=%0d got=%h exp=%h", c, gnt, exp_gnt()); end
      n_tests++;
      if (valid !== m_busy || busy !== m_busy) begin n_fail++; $display("FAIL rand_valid cyc=%0d got=%b/%b exp=%b", c, valid, busy, m_busy); end
      n_tests++;
      if (sel !== 4'(m_sel)) begin n_fail++; $display("FAIL rand_sel cyc=%0d got=%0d exp=%0d", c, sel, m_sel); end
      n_tests++;
    end
    rst = 1'b0;
  endtask

  initial begin
    m_busy = 0; m_sel = 0; m_ptr = 0; m_held = 0;
    test_reset();
    test_round_robin();
    test_timeout();
    test_wrap();
    test_early_drop();
    test_reset_mid_grant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
